// File: rtl/axis_pkg.sv
// Purpose: shared constants and helpers for the AXI-stream width converters.
// Latency: not applicable; this package holds no logic.
// Backpressure: not applicable.
package axis_pkg;

  // Largest lane ratio any converter in this family is built for.
  localparam int AXIS_MAX_RATIO = 16;

  // Counter width for n states; never narrower than one bit so RATIO=1 still has a counter.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_width_upsize_oreg.sv
// Purpose: output word register with a valid flag; data reads as zero while empty.
// Latency: 1 cycle from load to o_vld.
// Backpressure: holds word and o_vld until i_rdy; a load during a drain replaces the word with no bubble.
module axis_width_upsize_oreg #(
  parameter int W = 72
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_dat,
  input  logic         i_rdy,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  // Valid flag: set by a load, cleared by a drain that has no load alongside it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_vld <= 1'b1;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  // Word storage: only written on a load, so the word stays stable while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dat <= '0;
    end else if (i_load) begin
      r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_vld ? r_dat : '0;

endmodule

// File: rtl/axis_width_upsize.sv
// Purpose: packs RATIO narrow AXI-stream beats into one wide beat, lane 0 in the low bits.
// Latency: 1 cycle from the final-lane handshake to m_axis_tvalid; 1 beat/cycle sustained.
// Backpressure: partial lanes always accepted; final lane stalls while the output word is held.
// Optional build macro AXIS_WIDTH_UPSIZE_TLAST_EN adds tlast/tkeep and partial-word flush on tlast.
module axis_width_upsize
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int RATIO      = 4
) (
  input  logic                        axis_clk,
  input  logic                        axis_rst_n,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_WIDTH*RATIO-1:0] m_axis_tdata
`ifdef AXIS_WIDTH_UPSIZE_TLAST_EN
  ,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tlast,
  output logic [RATIO-1:0]            m_axis_tkeep
`endif
);

  localparam int              OW        = DATA_WIDTH * RATIO;
  localparam int              LW        = clog2_min1(RATIO);
  localparam logic [LW-1:0]   LAST_LANE = LW'(RATIO - 1);

  if (RATIO < 1 || RATIO > AXIS_MAX_RATIO) begin : g_bad_ratio
    $error("axis_width_upsize: RATIO out of range 1..16");
  end

  logic [LW-1:0] r_lane;
  logic [OW-1:0] r_pack;
  logic [OW-1:0] w_word;
  logic          w_tlast_in;
  logic          w_word_end;
  logic          w_s_hs;
  logic          w_load;
  logic          w_m_vld;

`ifdef AXIS_WIDTH_UPSIZE_TLAST_EN
  assign w_tlast_in = s_axis_tlast;
`else
  assign w_tlast_in = 1'b0;
`endif

  // A beat ends the word either by filling the last lane or by carrying tlast.
  assign w_word_end = (r_lane == LAST_LANE) | w_tlast_in;
  assign w_s_hs     = s_axis_tvalid & s_axis_tready;
  assign w_load     = w_s_hs & w_word_end;

  // Only a word-ending beat needs room in the output register.
  assign s_axis_tready = axis_rst_n & (~w_word_end | ~w_m_vld | m_axis_tready);

  // Merge the incoming beat into its lane; lanes above it are still zero in the pack register.
  always_comb begin
    w_word = r_pack;
    for (int k = 0; k < RATIO; k++) begin
      if (r_lane == LW'(k)) begin
        w_word[k*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
      end
    end
  end

  // Lane counter and pack register; both clear when a word is handed to the output stage.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (w_s_hs) begin
      if (w_word_end) begin
        r_lane <= '0;
        r_pack <= '0;
      end else begin
        r_lane <= r_lane + LW'(1);
        r_pack <= w_word;
      end
    end
  end

  assign m_axis_tvalid = w_m_vld;

`ifdef AXIS_WIDTH_UPSIZE_TLAST_EN
  logic [RATIO-1:0]    w_keep;
  logic [OW+RATIO:0]   w_oreg_dat;

  // Lanes 0..current are populated; a full word therefore gets all-ones.
  always_comb begin
    w_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      w_keep[k] = (LW'(k) <= r_lane);
    end
  end

  axis_width_upsize_oreg #(
    .W (OW + RATIO + 1)
  ) u_oreg (
    .i_clk   (axis_clk),
    .i_rst_n (axis_rst_n),
    .i_load  (w_load),
    .i_dat   ({s_axis_tlast, w_keep, w_word}),
    .i_rdy   (m_axis_tready),
    .o_vld   (w_m_vld),
    .o_dat   (w_oreg_dat)
  );

  assign m_axis_tdata = w_oreg_dat[OW-1:0];
  assign m_axis_tkeep = w_oreg_dat[OW+RATIO-1:OW];
  assign m_axis_tlast = w_oreg_dat[OW+RATIO];
`else
  axis_width_upsize_oreg #(
    .W (OW)
  ) u_oreg (
    .i_clk   (axis_clk),
    .i_rst_n (axis_rst_n),
    .i_load  (w_load),
    .i_dat   (w_word),
    .i_rdy   (m_axis_tready),
    .o_vld   (w_m_vld),
    .o_dat   (m_axis_tdata)
  );
`endif

endmodule

// File: tb/tb_axis_width_upsize.sv
// Purpose: directed and random self-checking bench for axis_width_upsize at DATA_WIDTH=18, RATIO=4.
// Latency: expects m_axis_tvalid one cycle after the final-lane handshake.
// Backpressure: exercises final-lane stall, drain-and-load in one cycle, and random tvalid/tready.
module tb_axis_width_upsize;

  localparam int DW = 18;
  localparam int R  = 4;
  localparam int OW = DW * R;
  localparam int NB = 10000;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [OW-1:0] m_axis_tdata;
`ifdef AXIS_WIDTH_UPSIZE_TLAST_EN
  logic          s_axis_tlast;
  logic          m_axis_tlast;
  logic [R-1:0]  m_axis_tkeep;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  axis_width_upsize #(
    .DATA_WIDTH (DW),
    .RATIO      (R)
  ) dut (
    .axis_clk      (axis_clk),
    .axis_rst_n    (axis_rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata)
`ifdef AXIS_WIDTH_UPSIZE_TLAST_EN
    ,
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep)
`endif
  );

  initial forever #5 axis_clk = ~axis_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  logic [OW-1:0] w1, w2, exp_word;
  logic [OW-1:0] mword, held;
  logic [OW-1:0] q[$];
  logic          hold, s_hs;
  int            mlane, sent, cyc, words;

  initial begin
    axis_rst_n    = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
`ifdef AXIS_WIDTH_UPSIZE_TLAST_EN
    s_axis_tlast  = 1'b0;
`endif

    // Reset state
    repeat (3) tick();
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
`ifdef AXIS_WIDTH_UPSIZE_TLAST_EN
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tlast", m_axis_tlast, 0);
`endif
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 18'h3ffff;
    #1 chk("rst_tready_with_valid", s_axis_tready, 0);
    tick();
    chk("rst_no_load", m_axis_tvalid, 0);
    s_axis_tvalid = 1'b0;
    axis_rst_n    = 1'b1;
    #1 chk("post_rst_tready", s_axis_tready, 1);

    // Basic packing: beats 1..4, word valid one cycle after the 4th handshake
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(i + 1);
      #1 chk("basic_tready", s_axis_tready, 1);
      chk("basic_tvalid_low", m_axis_tvalid, 0);
      tick();
    end
    s_axis_tvalid = 1'b0;
    chk("basic_tvalid", m_axis_tvalid, 1);
    chk("basic_tdata", m_axis_tdata, {18'd4, 18'd3, 18'd2, 18'd1});
    tick();
    chk("basic_drained", m_axis_tvalid, 0);
    chk("basic_zero_gated", m_axis_tdata, 0);

    // Continuous 16-beat stream
    for (int i = 0; i < 16; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(i + 'h100);
      #1 chk("stream_tready", s_axis_tready, 1);
      tick();
      chk("stream_tvalid", m_axis_tvalid, (i % 4) == 3);
      if ((i % 4) == 3) begin
        exp_word = {DW'(i + 'h100), DW'(i - 1 + 'h100), DW'(i - 2 + 'h100), DW'(i - 3 + 'h100)};
        chk("stream_tdata", m_axis_tdata, exp_word);
      end
    end
    s_axis_tvalid = 1'b0;
    tick();

    // Final-lane stall while the output word is held
    m_axis_tready = 1'b0;
    w1 = {18'h14, 18'h13, 18'h12, 18'h11};
    w2 = {18'h24, 18'h23, 18'h22, 18'h21};
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(i + 'h11);
      tick();
    end
    chk("stall_w1_vld", m_axis_tvalid, 1);
    chk("stall_w1_dat", m_axis_tdata, w1);
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = DW'(i + 'h21);
      #1 chk("stall_partial_tready", s_axis_tready, 1);
      tick();
      chk("stall_w1_held", m_axis_tdata, w1);
    end
    s_axis_tdata = 18'h24;
    #1 chk("stall_final_tready", s_axis_tready, 0);
    repeat (2) begin
      tick();
      chk("stall_tready_low", s_axis_tready, 0);
      chk("stall_vld_held", m_axis_tvalid, 1);
      chk("stall_dat_held", m_axis_tdata, w1);
    end
    m_axis_tready = 1'b1;
    #1 chk("stall_release_tready", s_axis_tready, 1);
    tick();
    s_axis_tvalid = 1'b0;
    chk("swap_vld", m_axis_tvalid, 1);
    chk("swap_dat", m_axis_tdata, w2);
    tick();
    chk("swap_drained", m_axis_tvalid, 0);

    // Reset mid-word with a word pending in the output register
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(i + 'h41);
      tick();
    end
    chk("prerst_vld", m_axis_tvalid, 1);
    s_axis_tvalid = 1'b0;
    axis_rst_n    = 1'b0;
    #1 chk("midrst_tready", s_axis_tready, 0);
    tick();
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_tdata", m_axis_tdata, 0);
    axis_rst_n    = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(i + 'hA);
      tick();
    end
    s_axis_tvalid = 1'b0;
    chk("midrst_word_vld", m_axis_tvalid, 1);
    chk("midrst_word_dat", m_axis_tdata, {18'hD, 18'hC, 18'hB, 18'hA});
    tick();

`ifdef AXIS_WIDTH_UPSIZE_TLAST_EN
    // Partial-word flush on tlast, then the next beat restarts at lane 0
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 18'h5;
    s_axis_tlast  = 1'b0;
    tick();
    s_axis_tdata  = 18'h6;
    s_axis_tlast  = 1'b1;
    tick();
    s_axis_tlast  = 1'b0;
    chk("flush_vld", m_axis_tvalid, 1);
    chk("flush_dat", m_axis_tdata, {36'h0, 18'h6, 18'h5});
    chk("flush_keep", m_axis_tkeep, 4'b0011);
    chk("flush_last", m_axis_tlast, 1);
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata = DW'(i + 7);
      tick();
    end
    s_axis_tvalid = 1'b0;
    chk("after_flush_dat", m_axis_tdata, {18'd10, 18'd9, 18'd8, 18'd7});
    chk("after_flush_keep", m_axis_tkeep, 4'b1111);
    chk("after_flush_last", m_axis_tlast, 0);
    tick();
`endif

    // Random tvalid/tready against a packing scoreboard
    mword = '0;
    mlane = 0;
    sent  = 0;
    cyc   = 0;
    words = 0;
    hold  = 1'b0;
    held  = '0;
    m_axis_tready = 1'b0;
    while ((sent < NB || q.size() != 0) && cyc < 60000) begin
      @(negedge axis_clk);
      cyc++;
      if (hold) begin
        chk("rand_hold_vld", m_axis_tvalid, 1);
        chk("rand_hold_dat", m_axis_tdata, held);
      end
      hold = m_axis_tvalid & ~m_axis_tready;
      held = m_axis_tdata;
      s_hs = s_axis_tvalid & s_axis_tready;
      if (s_hs) begin
        mword[mlane*DW +: DW] = s_axis_tdata;
        mlane++;
        sent++;
        if (mlane == R) begin
          q.push_back(mword);
          mword = '0;
          mlane = 0;
        end
      end
      if (m_axis_tvalid & m_axis_tready) begin
        words++;
        if (q.size() == 0) begin
          chk("rand_extra_word", 1, 0);
        end else begin
          chk("rand_word", m_axis_tdata, q.pop_front());
        end
      end
      @(posedge axis_clk);
      #1;
      if (!s_axis_tvalid || s_hs) begin
        if (sent < NB) begin
          s_axis_tvalid = 1'($urandom_range(0, 1));
          s_axis_tdata  = DW'($urandom);
        end else begin
          s_axis_tvalid = 1'b0;
        end
      end
      m_axis_tready = 1'($urandom_range(0, 1));
    end
    chk("rand_timeout", cyc < 60000, 1);
    chk("rand_word_count", words, NB / R);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
